path_segment_alu: RTL and testbench

//  Parametrised successor of the two-source add/multiply path-segment block: registers operands

---
 rtl/path_segment_pkg.sv | 27 ++
 rtl/path_segment_alu_mult.sv | 40 ++++
 rtl/path_segment_alu.sv | 159 +++++++++++++++
 tb/tb_path_segment_alu.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/path_segment_pkg.sv
// Shared types for the path-segment ALU: op encoding, pipeline stage record,
// and the select-width helper used to size the source-select ports.
package path_segment_pkg;

    typedef enum logic [1:0] {
        OP_ADD      = 2'b00,
        OP_SUB      = 2'b01,
        OP_MUL      = 2'b10,
        OP_PASS_MAC = 2'b11
    } op_e;

    // Widest operand the stage record can carry; WIDTH must not exceed this.
    localparam int PS_MAX_W = 64;

    typedef struct packed {
        logic                valid;
        op_e                 op;
        logic                tc;
        logic [PS_MAX_W-1:0] alu_res;
    } stage_t;

    // Width of a source index; at least one bit even for a single source.
    function automatic int ps_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/path_segment_alu_mult.sv
// ps_mult_pipe: H x H multiplier with a STAGES-deep register chain for
// retiming. tc chooses two's-complement or unsigned operand interpretation.
module ps_mult_pipe #(
    parameter int H      = 8,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           en,
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    input  logic           tc,
    output logic [2*H-1:0] prod
);

    logic signed [2*H+1:0] a_ext;
    logic signed [2*H+1:0] b_ext;
    logic signed [2*H+1:0] full;
    logic                  unused_hi;
    logic [2*H-1:0]        prod_p [STAGES];

    // Extending by the operand MSB only when signed makes one multiplier
    // serve both interpretations; the low 2H bits are the exact product.
    assign a_ext = $signed({{(H+2){tc & a[H-1]}}, a});
    assign b_ext = $signed({{(H+2){tc & b[H-1]}}, b});
    assign full  = a_ext * b_ext;
    assign unused_hi = ^full[2*H+1:2*H];

    // Product register chain; frozen as a whole while the pipe is stalled
    always_ff @(posedge clk) begin
        if (en) begin
            prod_p[0] <= full[2*H-1:0];
            for (int i = 1; i < STAGES; i++) begin
                prod_p[i] <= prod_p[i-1];
            end
        end
    end

    assign prod = prod_p[STAGES-1];

endmodule

// File: rtl/path_segment_alu.sv
// path_segment_alu: picks A/B from NUM_SRC source buses, registers them (S0),
// runs a MUL_STAGES-deep execute pipe and a registered output stage with
// valid/ready flow control. Latency MUL_STAGES+2 when unstalled.
// Optional feature: define PS_MAC_EN to turn op 11 into multiply-accumulate
// (otherwise op 11 passes A through and no accumulator exists).
module path_segment_alu
    import path_segment_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int NUM_SRC    = 4,
    parameter  int MUL_STAGES = 2,
    localparam int SEL_W      = ps_sel_w(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] src,
    input  logic [SEL_W-1:0]         sel_a,
    input  logic [SEL_W-1:0]         sel_b,
    input  logic [1:0]               op,
    input  logic                     tc,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int H = WIDTH / 2;

    logic             stall;
    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic             vld_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    op_e              op_p0;
    logic             tc_p0;

    stage_t           ex_p [1:MUL_STAGES];
    logic [WIDTH-1:0] prod_e;
    logic             unused_stage;

`ifdef PS_MAC_EN
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mac_sum;
`endif

    // Non-multiply results are produced here and then just ride the pipe
    function automatic logic [WIDTH-1:0] alu_eval(input op_e o,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (o)
            OP_ADD:      return a + b;
            OP_SUB:      return a - b;
`ifndef PS_MAC_EN
            OP_PASS_MAC: return a;
`endif
            default:     return '0;
        endcase
    endfunction

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // Source selectors; an index with no matching source leaves operand 0
    always_comb begin
        opa = '0;
        opb = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_a == SEL_W'(i)) opa = src[i*WIDTH +: WIDTH];
            if (sel_b == SEL_W'(i)) opb = src[i*WIDTH +: WIDTH];
        end
    end

    // ---- S0: operand capture ----
    // Valid advances every unstalled cycle; operands load only on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= in_valid;
        end
        if (accept) begin
            a_p0  <= opa;
            b_p0  <= opb;
            op_p0 <= op_e'(op);
            tc_p0 <= tc;
        end
    end

    // ---- S0 -> E1..E{MUL_STAGES}: execute pipe ----
    // ALU result computed on entry to E1 and shifted alongside the multiplier
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= MUL_STAGES; i++) begin
                ex_p[i].valid <= 1'b0;
            end
        end else if (adv) begin
            ex_p[1] <= '{valid:   vld_p0,
                         op:      op_p0,
                         tc:      tc_p0,
                         alu_res: PS_MAX_W'(alu_eval(op_p0, a_p0, b_p0))};
            for (int i = 2; i <= MUL_STAGES; i++) begin
                ex_p[i] <= ex_p[i-1];
            end
        end
    end

    ps_mult_pipe #(
        .H      (H),
        .STAGES (MUL_STAGES)
    ) u_mult (
        .clk  (clk),
        .en   (adv),
        .a    (a_p0[H-1:0]),
        .b    (b_p0[H-1:0]),
        .tc   (tc_p0),
        .prod (prod_e)
    );

    // The sign mode and the record's spare high bits are not needed past E{MUL_STAGES}
    assign unused_stage = ex_p[MUL_STAGES].tc ^ (^(ex_p[MUL_STAGES].alu_res >> WIDTH));

`ifdef PS_MAC_EN
    assign mac_sum = acc + prod_e;
`endif

    // ---- E{MUL_STAGES} -> output register ----
    // Bubbles clear out_valid but leave out_data (and acc) untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef PS_MAC_EN
            acc       <= '0;
`endif
        end else if (adv) begin
            out_valid <= ex_p[MUL_STAGES].valid;
            if (ex_p[MUL_STAGES].valid) begin
                case (ex_p[MUL_STAGES].op)
                    OP_MUL: out_data <= prod_e;
`ifdef PS_MAC_EN
                    OP_PASS_MAC: begin
                        out_data <= mac_sum;
                        acc      <= mac_sum;
                    end
`endif
                    default: out_data <= ex_p[MUL_STAGES].alu_res[WIDTH-1:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_path_segment_alu.sv
// Directed bench for path_segment_alu at WIDTH=16, NUM_SRC=4, MUL_STAGES=2.
// Honours PS_MAC_EN the same way the design does.
module tb_path_segment_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] src;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [1:0]  op;
    logic        tc;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       nm;
        logic [63:0] src;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  op;
        logic        tc;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];
    vec_t stim_q[$];

    path_segment_alu #(
        .WIDTH      (16),
        .NUM_SRC    (4),
        .MUL_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src       (src),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .op        (op),
        .tc        (tc),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // A on src0, B on src1, filler on the unselected buses
    function automatic vec_t mk(input string nm, input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] o, input logic t, input logic [15:0] e);
        vec_t v;
        v.nm  = nm;
        v.src = {16'hBEEF, 16'hDEAD, b, a};
        v.sa  = 2'd0;
        v.sb  = 2'd1;
        v.op  = o;
        v.tc  = t;
        v.exp = e;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        src   = v.src;
        sel_a = v.sa;
        sel_b = v.sb;
        op    = v.op;
        tc    = v.tc;
    endtask

    // Single op, unstalled: checks result and accept-to-out_valid latency
    task automatic run_vec(input vec_t v);
        bit got;
        got = 1'b0;
        @(negedge clk);
        drive(v);
        in_valid = 1'b1;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                got = 1'b1;
                chk({v.nm, "_data"}, 32'(out_data), 32'(v.exp));
                chk({v.nm, "_lat"}, 32'(k), 32'd4);
            end
        end
        if (!got) chk({v.nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Streams stim_q back-to-back; out_ready is low for stall_len cycles from stall_at
    task automatic run_stream(input string nm, input int stall_at, input int stall_len);
        int          cyc;
        int          sent;
        int          rcvd;
        int          nexp;
        int          last_cyc;
        int          extra;
        bit          held_ok;
        logic [15:0] held;
        logic [15:0] exp_q[$];
        cyc = 0; sent = 0; rcvd = 0; last_cyc = -1; held_ok = 1'b0; held = '0;
        nexp = stim_q.size();
        while (rcvd < nexp && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (sent < nexp) begin
                drive(stim_q[sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                chk({nm, "_in_ready_stalled"}, 32'(in_ready), 32'd0);
                if (held_ok) chk({nm, "_held"}, 32'(out_data), 32'(held));
                held    = out_data;
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({nm, "_extra_result"}, 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk({nm, "_data"}, 32'(out_data), 32'(exp_q.pop_front()));
                end
                if (rcvd == 0) chk({nm, "_first_lat"}, 32'(cyc), 32'd4);
                else if (stall_len == 0) chk({nm, "_consecutive"}, 32'(cyc), 32'(last_cyc + 1));
                last_cyc = cyc;
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(stim_q[sent].exp);
                sent++;
            end
            cyc++;
        end
        chk({nm, "_count"}, 32'(rcvd), 32'(nexp));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk({nm, "_no_dup"}, 32'(extra), 32'd0);
        stim_q.delete();
    endtask

    initial begin
        int stray;
        rst       = 1'b1;
        src       = '0;
        sel_a     = '0;
        sel_b     = '0;
        op        = '0;
        tc        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        tbl.push_back(mk("add_wrap",   16'hFFFF, 16'h0002, 2'b00, 1'b0, 16'h0001));
        tbl.push_back(mk("sub_pos",    16'h0005, 16'h0003, 2'b01, 1'b0, 16'h0002));
        tbl.push_back(mk("sub_neg",    16'h0003, 16'h0005, 2'b01, 1'b0, 16'hFFFE));
        tbl.push_back(mk("sub_0m1",    16'h0000, 16'h0001, 2'b01, 1'b0, 16'hFFFF));
        tbl.push_back(mk("mul_u_ff",   16'hAAFF, 16'h55FF, 2'b10, 1'b0, 16'hFE01));
        tbl.push_back(mk("mul_s_ff",   16'hAAFF, 16'h55FF, 2'b10, 1'b1, 16'h0001));
        tbl.push_back(mk("mul_u_fe3",  16'h00FE, 16'h0003, 2'b10, 1'b0, 16'h02FA));
        tbl.push_back(mk("mul_s_fe3",  16'h00FE, 16'h0003, 2'b10, 1'b1, 16'hFFFA));
        tbl.push_back(mk("mul_u_min",  16'h1280, 16'h347F, 2'b10, 1'b0, 16'h3F80));
        tbl.push_back(mk("mul_s_min",  16'h1280, 16'h347F, 2'b10, 1'b1, 16'hC080));
`ifndef PS_MAC_EN
        tbl.push_back(mk("pass_a",     16'h1234, 16'h5678, 2'b11, 1'b0, 16'h1234));
`endif
        begin
            vec_t v;
            v = mk("add_sel13", 16'd0, 16'd0, 2'b00, 1'b0, 16'h0006);
            v.src = {16'd4, 16'd3, 16'd2, 16'd1};
            v.sa  = 2'd1;
            v.sb  = 2'd3;
            tbl.push_front(v);
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) run_vec(tbl[i]);

        // SUB pair back-to-back: results on consecutive cycles
        stim_q.push_back(mk("s1", 16'h0005, 16'h0003, 2'b01, 1'b0, 16'h0002));
        stim_q.push_back(mk("s2", 16'h0003, 16'h0005, 2'b01, 1'b0, 16'hFFFE));
        run_stream("sub_b2b", 100, 0);

        // Six ADDs with a three-cycle consumer stall mid-stream
        for (int i = 0; i < 6; i++) begin
            stim_q.push_back(mk("a", 16'(i * 3 + 1), 16'(i * 256), 2'b00, 1'b0,
                                16'(i * 3 + 1 + i * 256)));
        end
        run_stream("add_stall", 5, 3);

        // Reset with three ops in flight
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(mk("r", 16'h0100, 16'h0011, 2'b00, 1'b0, 16'h0111));
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_out_data", 32'(out_data), 32'd0);
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("rst_mid_no_stale", 32'(stray), 32'd0);

`ifdef PS_MAC_EN
        stim_q.push_back(mk("m1", 16'h0002, 16'h0003, 2'b11, 1'b0, 16'h0006));
        stim_q.push_back(mk("m2", 16'h0002, 16'h0003, 2'b11, 1'b0, 16'h000C));
        stim_q.push_back(mk("m3", 16'h0002, 16'h0003, 2'b11, 1'b0, 16'h0012));
        run_stream("mac_x3", 100, 0);
`else
        run_vec(mk("op11_pass", 16'h0002, 16'h0003, 2'b11, 1'b0, 16'h0002));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute guard so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
